branch_resolve_unit: RTL
========================

# branch_resolve_unit

Resolves branches and jumps leaving EX: compares the actual outcome with the prediction made at fetch, raises a registered redirect/flush on a mispredict, and queues BTB target updates for the BTB write port. It sits between the EX stage and the BTB. It drives the BTB's write index and write data, and honours a write-ready handshake so that update bursts are not lost when the BTB port is busy. It also keeps branch and mispredict performance counters.

## Interface
- INDEX_BITS, 10, BTB index width; the index is pc[INDEX_BITS-1:0].
- QDEPTH, 4, update-queue depth in entries; must be a power of two, minimum 2.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  one-cycle pulse per resolved control-flow instruction; the pipeline never repeats an instruction.
- ex_is_jump  in  1  unconditional jump (JAL/JALR); treated as actually taken regardless of ex_taken.
- ex_pc  in  32  PC of the resolved instruction.
- ex_taken  in  1  actual direction of a conditional branch.
- ex_target  in  32  actual target address.
- ex_pred_taken  in  1  direction predicted at fetch.
- ex_pred_target  in  32  target predicted at fetch (BTB output).
- redirect  out  1  registered one-cycle pulse: mispredict detected.
- redirect_pc  out  32  correct fetch PC; valid while redirect is high.
- btb_we  out  1  queue head valid; a BTB write is requested.
- btb_windex  out  INDEX_BITS  index of the head entry.
- btb_wdata  out  32  target of the head entry.
- btb_ready  in  1  BTB accepts the write; a transfer occurs when btb_we && btb_ready.
- q_overflow  out  1  registered one-cycle pulse: an update was dropped because the queue was full.
- branch_count  out  32  resolved-instruction count; wraps.
- mispredict_count  out  32  mispredict count; wraps.

## Operation
- Effective taken: eff_taken = ex_is_jump | ex_taken.
- Mispredict, evaluated only when ex_valid: (eff_taken != ex_pred_taken) or (eff_taken && ex_pred_target != ex_target).
- Correct PC: eff_taken ? ex_target : ex_pc + 32'd4. The addition is 32-bit and wraps modulo 2^32.
- Update needed, evaluated only when ex_valid: eff_taken && (ex_pred_target != ex_target || !ex_pred_taken). The entry is {ex_pc[INDEX_BITS-1:0], ex_target}.
- A not-taken mispredict does not create a BTB update.

Update queue (circular FIFO of QDEPTH entries):
- Head entry drives btb_windex and btb_wdata combinationally.
- btb_we = (count != 0).
- Dequeue when btb_we && btb_ready.
- Enqueue when update needed and (count < QDEPTH, or a dequeue happens in the same cycle).
- If the queue is full and no dequeue happens that cycle, the new entry is dropped, existing entries are kept, and q_overflow pulses on the next cycle.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo QDEPTH. Entries are not coalesced; duplicate indices are written in order.

Counters:
- branch_count increments on every ex_valid.
- mispredict_count increments on every mispredict.

Reset (asserted at any time, including mid-burst):
- Queue emptied, pointers and count set to 0.
- All outputs set to 0: redirect, redirect_pc, btb_we, btb_windex, btb_wdata, q_overflow, both counters.
- In-flight entries are discarded.

## Timing
- ex_valid in cycle N gives redirect/redirect_pc in cycle N+1, exactly one cycle high. Back-to-back mispredicts give back-to-back pulses, each carrying its own PC.
- Enqueue in cycle N makes the entry visible at the head no earlier than cycle N+1. With an empty queue and btb_ready=1, the BTB write completes in N+1.
- btb_windex and btb_wdata hold stable while btb_we=1 and btb_ready=0.
- Counters are registered and reflect the event in cycle N+1.
- Steady state: one enqueue and one dequeue per cycle are sustainable.

## Test plan
- Correctly predicted taken branch (pc=0x100, target=0x200, pred_taken=1, pred_target=0x200): no redirect, no btb_we; branch_count=1, mispredict_count=0.
- Not-taken branch predicted taken (pc=0x104, pred_taken=1): redirect=1 in N+1 with redirect_pc=0x108; no queue entry.
- Jump with wrong target (pc=0x3FC, ex_is_jump=1, target=0x800, pred_target=0x400), btb_ready=1: redirect_pc=0x800 in N+1; btb_we=1 in N+1 with windex=0x3FC, wdata=0x800; queue empty in N+2.
- Hold btb_ready=0 and issue 5 updates: first 4 queued, 5th dropped, q_overflow pulses once. Release ready: 4 writes in FIFO order on consecutive cycles, then btb_we=0.
- Full queue with a simultaneous dequeue and enqueue: no overflow, count stays 4, order preserved across pointer wrap.
- Assert rst_n low while 3 entries are queued and a redirect is pending: all outputs 0 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// BTB write port: the resolver requests writes, the BTB accepts them.
// A write transfers on a cycle where btb_we and btb_ready are both high.
interface branch_resolve_unit_if #(
    parameter int INDEX_BITS = 10
);
    logic                  btb_we;
    logic [INDEX_BITS-1:0] btb_windex;
    logic [31:0]           btb_wdata;
    logic                  btb_ready;

    modport master (
        output btb_we,
        output btb_windex,
        output btb_wdata,
        input  btb_ready
    );

    modport slave (
        input  btb_we,
        input  btb_windex,
        input  btb_wdata,
        output btb_ready
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution: mispredict redirect, BTB update queue, perf counters.
// Updates wait in a small FIFO so BTB back-pressure never loses a burst.
module branch_resolve_unit #(
    parameter int INDEX_BITS = 10,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        q_overflow,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count,
    branch_resolve_unit_if.master btb
);
    localparam int PW = $clog2(QDEPTH);

    logic [INDEX_BITS-1:0] q_index  [QDEPTH];
    logic [31:0]           q_target [QDEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;

    logic        eff_taken;
    logic        mispredict;
    logic        upd_need;
    logic [31:0] correct_pc;
    logic        full;
    logic        deq;
    logic        enq;
    logic        drop;

    // Outcome vs. prediction for the instruction leaving EX.
    always_comb begin
        eff_taken  = ex_is_jump | ex_taken;
        mispredict = ex_valid &&
                     ((eff_taken != ex_pred_taken) ||
                      (eff_taken && (ex_pred_target != ex_target)));
        upd_need   = ex_valid && eff_taken &&
                     ((ex_pred_target != ex_target) || !ex_pred_taken);
        correct_pc = eff_taken ? ex_target : ex_pc + 32'd4;
    end

    // A full queue still accepts when the head leaves in the same cycle.
    assign full       = (count == (PW+1)'(QDEPTH));
    assign btb.btb_we = (count != '0);
    assign deq        = btb.btb_we && btb.btb_ready;
    assign enq        = upd_need && (!full || deq);
    assign drop       = upd_need && full && !deq;

    // Head is gated so the write port reads zero whenever the queue is empty.
    assign btb.btb_windex = btb.btb_we ? q_index[rd_ptr]  : '0;
    assign btb.btb_wdata  = btb.btb_we ? q_target[rd_ptr] : '0;

    // Queue storage: write the tail slot on enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_index[i]  <= '0;
                q_target[i] <= '0;
            end
        end else if (enq) begin
            q_index[wr_ptr]  <= ex_pc[INDEX_BITS-1:0];
            q_target[wr_ptr] <= ex_target;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered redirect and overflow pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            q_overflow  <= 1'b0;
        end else begin
            redirect    <= mispredict;
            redirect_pc <= mispredict ? correct_pc : '0;
            q_overflow  <= drop;
        end
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid)   branch_count     <= branch_count + 32'd1;
            if (mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule
